// File: rtl/multdiv_pkg.sv
// Shared encodings and defaults for the iterative signed multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // States during which the unit reports itself busy
    function automatic logic is_busy_state(input state_t s);
        return (s == ST_MUL) || (s == ST_DIV) || (s == ST_FIX);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/done handshake and HI/LO result bus between control FSM and mult/div unit.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = multdiv_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/multdiv_sign_fix.sv
// Final two's-complement sign correction of the unsigned magnitude results.
module multdiv_sign_fix
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               op,
    input  logic               neg_q,
    input  logic               neg_r,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quo,
    input  logic [WIDTH-1:0]   rem,
    output logic [WIDTH-1:0]   hi_c,
    output logic [WIDTH-1:0]   lo_c
);

    logic [2*WIDTH-1:0] prod_s;

    // Product and quotient follow sign(a)^sign(b); remainder follows sign(a)
    always_comb begin
        hi_c   = '0;
        lo_c   = '0;
        prod_s = neg_q ? -prod : prod;
        if (op == OP_MULT) begin
            {hi_c, lo_c} = prod_s;
        end else begin
            lo_c = neg_q ? -quo : quo;
            hi_c = neg_r ? -rem : rem;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MIPS mult/div unit: one operand bit per cycle, sign fix, done pulse.
// Define MULT_DIV_EARLY_TERM_EN to end MUL once the remaining multiplier bits are zero.
module mult_div_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_div_unit_if.slave       bus
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             op_q, neg_q, neg_r;
    logic [PW-1:0]    acc, mcand;
    logic [WIDTH:0]   mplier, dvsr;
    logic [WIDTH-1:0] quo, rem;

    logic             busy_q, done_q, div_zero_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
    logic             b_zero;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic             last_mul;
    logic [WIDTH-1:0] hi_c, lo_c;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // WIDTH+1 bit magnitudes so that |-2^(WIDTH-1)| is exact
    always_comb begin
        a_ext  = {bus.a[WIDTH-1], bus.a};
        b_ext  = {bus.b[WIDTH-1], bus.b};
        a_mag  = a_ext[WIDTH] ? -a_ext : a_ext;
        b_mag  = b_ext[WIDTH] ? -b_ext : b_ext;
        b_zero = (bus.b == '0);
    end

    // Restoring division step: shift next dividend bit into the partial remainder
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        fits  = (trial >= dvsr);
    end

`ifdef MULT_DIV_EARLY_TERM_EN
    assign last_mul = (cnt == CNT_LAST) || (mplier[WIDTH:1] == '0);
`else
    assign last_mul = (cnt == CNT_LAST);
`endif

    multdiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .op    (op_q),
        .neg_q (neg_q),
        .neg_r (neg_r),
        .prod  (acc),
        .quo   (quo),
        .rem   (rem),
        .hi_c  (hi_c),
        .lo_c  (lo_c)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MULT) begin
                        state_nx = ST_MUL;
                    end else if (b_zero) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_DIV;
                    end
                end
            end
            ST_MUL:  if (last_mul) state_nx = ST_FIX;
            ST_DIV:  if (cnt == CNT_LAST) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt        <= '0;
            op_q       <= OP_MULT;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            dvsr       <= '0;
            quo        <= '0;
            rem        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            busy_q <= is_busy_state(state_nx);
            done_q <= (state_nx == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cnt        <= '0;
                        op_q       <= bus.op;
                        neg_q      <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_r      <= bus.a[WIDTH-1];
                        acc        <= '0;
                        mcand      <= PW'(a_mag);
                        mplier     <= b_mag;
                        dvsr       <= b_mag;
                        quo        <= a_mag[WIDTH-1:0];
                        rem        <= WIDTH'(a_mag[WIDTH]);
                        div_zero_q <= (bus.op == OP_DIV) && b_zero;
                    end
                end
                ST_MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                ST_DIV: begin
                    rem <= fits ? WIDTH'(trial - dvsr) : WIDTH'(trial);
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + CNT_W'(1);
                end
                ST_FIX: begin
                    hi_q <= hi_c;
                    lo_q <= lo_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, scoreboard and corner sequences.
module tb_mult_div_unit;

    localparam int unsigned W = 32;
`ifdef MULT_DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[12];

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference result computed with 64-bit signed arithmetic
    function automatic void model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic signed [63:0] sa, sb, p, q, r;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        if (op == 1'b0) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Edges after the start edge until done is visible for a multiply
    function automatic int mul_lat(input logic [W-1:0] b);
        logic [W-1:0] m;
        int top;
        m   = b[W-1] ? -b : b;
        top = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) top = i;
        end
        return EARLY ? top + 2 : 33;
    endfunction

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (bus.done) begin
            exp_t e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h, expected no done", bus.hi, bus.lo);
            end else begin
                e = exp_q.pop_front();
                check("hi", 64'(bus.hi), 64'(e.hi));
                check("lo", 64'(bus.lo), 64'(e.lo));
                check("div_zero", 64'(bus.div_zero), 64'(e.dz));
            end
        end
    end

    task automatic wait_done(input int exp_lat);
        int lat = 0;
        bit busy_ok = 1'b1;
        while (!bus.done && lat < 200) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("done_seen", 64'(bus.done), 64'd1);
        check("latency", 64'(lat), 64'(exp_lat));
        if (exp_lat > 0) check("busy_until_done", 64'(busy_ok), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    task automatic pulse_start(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          input int exp_lat);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        exp_q.push_back(e);
        pulse_start(op, a, b);
        wait_done(exp_lat);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rhi, rlo;
        logic         rop;
        int           dc;
        bit           quiet;

        vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[2]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[3]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[4]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[5]  = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[10] = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_div_zero", 64'(bus.div_zero), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0,
                   vecs[i].op ? 33 : mul_lat(vecs[i].b));
        end

        // Divide by zero keeps hi/lo, flag is sticky until the next start
        run_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, mul_lat(32'd5));
        run_op(1'b1, 32'd9, 32'd0, 32'd0, 32'd15, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("dz_sticky", 64'(bus.div_zero), 64'd1);
        check("dz_hold_lo", 64'(bus.lo), 64'd15);
        run_op(1'b0, 32'd5, 32'd1, 32'd0, 32'd5, 1'b0, mul_lat(32'd1));

        // Second start during a multiply must be dropped
        begin
            exp_t e;
            e.hi = 32'h0000_0001;
            e.lo = 32'h8000_002A;
            e.dz = 1'b0;
            exp_q.push_back(e);
        end
        dc = done_cnt;
        pulse_start(1'b0, 32'd6, 32'h4000_0007);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(mul_lat(32'h4000_0007) - 10);
        repeat (40) @(negedge clk);
        check("single_done", 64'(done_cnt - dc), 64'd1);

        // Reset at E15 of a divide abandons it without a done pulse
        dc = done_cnt;
        pulse_start(1'b1, 32'hFFFF_FF9C, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_done", 64'(bus.done), 64'd0);
        check("mid_rst_hi", 64'(bus.hi), 64'd0);
        check("mid_rst_lo", 64'(bus.lo), 64'd0);
        check("mid_rst_dz", 64'(bus.div_zero), 64'd0);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) quiet = 1'b0;
        end
        check("no_done_after_rst", 64'(quiet), 64'd1);
        check("rst_done_count", 64'(done_cnt - dc), 64'd0);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, mul_lat(32'h0001_0000));

        // Random operands against the 64-bit reference
        for (int i = 0; i < 16; i++) begin
            rop = 1'(i % 2);
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i % 5 == 0) ra = -ra;
            if (rop && rb == '0) rb = 32'd1;
            model(rop, ra, rb, rhi, rlo);
            run_op(rop, ra, rb, rhi, rlo, 1'b0, rop ? 33 : mul_lat(rb));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
